// File: rtl/acc_dump.sv
// Streams a snapshot of the accumulator out over the UART transmitter, LSB byte first.
// Define ACC_DUMP_FRAME_EN to wrap the data in an 8'hA5 header and an XOR checksum byte.
module acc_dump #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic [WIDTH-1:0] big,
  input  logic             busy_tx,
  output logic             transmit,
  output logic [7:0]       data_tx,
  output logic             active,
  output logic             done
);

  localparam int NBYTES = WIDTH / 8;
`ifdef ACC_DUMP_FRAME_EN
  localparam int NITEMS = NBYTES + 2;
`else
  localparam int NITEMS = NBYTES;
`endif
  localparam int CW = (NITEMS > 1) ? $clog2(NITEMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NITEMS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shadow;
  logic [7:0]       cur;

`ifdef ACC_DUMP_FRAME_EN
  logic [7:0] csum;

  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < NBYTES; k++) csum = csum ^ shadow[8*k +: 8];
  end

  // Item 0 is the header, the last item is the checksum, data sits in between.
  always_comb begin
    cur = 8'h00;
    if (cnt == '0) begin
      cur = 8'hA5;
    end else if (cnt == LAST) begin
      cur = csum;
    end else begin
      for (int k = 0; k < NBYTES; k++)
        if (cnt == CW'(k + 1)) cur = shadow[8*k +: 8];
    end
  end
`else
  always_comb begin
    cur = 8'h00;
    for (int k = 0; k < NBYTES; k++)
      if (cnt == CW'(k)) cur = shadow[8*k +: 8];
  end
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shadow  <= '0;
      data_tx <= 8'h00;
      active  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow <= big;
            cnt    <= '0;
            active <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!busy_tx) begin
            data_tx <= cur;
            state   <= S_SEND;
          end
        end
        S_SEND: state <= S_ACK;
        S_ACK: begin
          // Only move on once the UART has shown busy, so each byte is loaded exactly once.
          if (busy_tx) begin
            if (cnt == LAST) begin
              state <= S_FIN;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_WAIT;
            end
          end
        end
        S_FIN: begin
          if (!busy_tx) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // done is high during the final FIN cycle, so a start landing on it is ignored.
  assign transmit = (state == S_SEND);
  assign done     = (state == S_FIN) && !busy_tx;

endmodule

// File: tb/tb_acc_dump.sv
// Scoreboard bench for acc_dump: stimulus pushes expected bytes, a negedge monitor pops
// them on every transmit pulse; a small UART model holds busy_tx for 10 cycles per byte.
`timescale 1ns/1ps
module tb_acc_dump;
  localparam int WIDTH  = 128;
  localparam int NBYTES = WIDTH / 8;
`ifdef ACC_DUMP_FRAME_EN
  localparam int NTX = NBYTES + 2;
`else
  localparam int NTX = NBYTES;
`endif
  localparam logic [WIDTH-1:0] P0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [WIDTH-1:0] P1 = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic             clk = 1'b0;
  logic             nRst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] big = '0;
  logic             hold_busy = 1'b0;
  logic             uart_busy;
  logic             busy_tx;
  logic             transmit;
  logic [7:0]       data_tx;
  logic             active;
  logic             done;
  int               uart_cnt;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  int done_count = 0;
  bit seen_busy = 1'b1;

  assign busy_tx = uart_busy | hold_busy;

  acc_dump #(.WIDTH(WIDTH)) dut (
    .clk(clk), .nRst(nRst), .start(start), .big(big), .busy_tx(busy_tx),
    .transmit(transmit), .data_tx(data_tx), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each transmit pulse
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      uart_busy <= 1'b0;
      uart_cnt  <= 0;
    end else if (transmit) begin
      uart_busy <= 1'b1;
      uart_cnt  <= 10;
    end else if (uart_cnt > 1) begin
      uart_cnt <= uart_cnt - 1;
    end else begin
      uart_cnt  <= 0;
      uart_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!nRst) begin
      seen_busy = 1'b1;
    end else begin
      if (transmit) begin
        tx_count++;
        check("tx_after_busy", 32'(seen_busy), 32'd1);
        seen_busy = 1'b0;
        if (exp_q.size() == 0) check("unexpected_tx", 32'(data_tx), 32'hFFFF_FFFF);
        else check("data_tx", 32'(data_tx), 32'(exp_q.pop_front()));
      end else if (busy_tx) begin
        seen_busy = 1'b1;
      end
      if (done) begin
        done_count++;
        check("bytes_left_at_done", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic push_dump(input logic [WIDTH-1:0] v);
    logic [7:0] cs;
    cs = 8'h00;
`ifdef ACC_DUMP_FRAME_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < NBYTES; k++) begin
      exp_q.push_back(v[8*k +: 8]);
      cs = cs ^ v[8*k +: 8];
    end
`ifdef ACC_DUMP_FRAME_EN
    exp_q.push_back(cs);
`else
    if (cs == 8'h00) cs = 8'h00;
`endif
  endtask

  task automatic do_start(input logic [WIDTH-1:0] v);
    @(negedge clk);
    big   = v;
    start = 1'b1;
    push_dump(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_count <= base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_count <= base) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_tx(input int target);
    int n;
    n = 0;
    while (tx_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx_count < target) check("tx_timeout", 32'(tx_count), 32'(target));
  endtask

  initial begin
    int k, tb0, db0;
    // 1: reset held with start high and busy toggling
    nRst = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hold_busy = ~hold_busy;
    end
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_data_tx", 32'(data_tx), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    hold_busy = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_active", 32'(active), 32'd0);

    // 2: byte k = k, latency and full stream
    tb0 = tx_count; db0 = done_count;
    @(negedge clk);
    big = P0; start = 1'b1; push_dump(P0);
    @(negedge clk);
    start = 1'b0;
    check("active_after_start", 32'(active), 32'd1);
    k = 1;
    while (!transmit && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("first_tx_latency", 32'(k + 1), 32'd3);
    wait_done(db0);
    @(negedge clk);
    check("t2_tx_count", 32'(tx_count - tb0), 32'(NTX));
    check("t2_done_count", 32'(done_count - db0), 32'd1);
    check("t2_active_low", 32'(active), 32'd0);
    check("t2_done_low", 32'(done), 32'd0);

    // 3: big changes one cycle after start
    tb0 = tx_count; db0 = done_count;
    @(negedge clk);
    big = P0; start = 1'b1; push_dump(P0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    big = '1;
    wait_done(db0);
    @(negedge clk);
    check("t3_tx_count", 32'(tx_count - tb0), 32'(NTX));

    // Second pattern
    tb0 = tx_count; db0 = done_count;
    do_start(P1);
    wait_done(db0);
    @(negedge clk);
    check("p1_tx_count", 32'(tx_count - tb0), 32'(NTX));

    // 4: busy high at start for 50 cycles
    tb0 = tx_count; db0 = done_count;
    hold_busy = 1'b1;
    do_start(P0);
    repeat (50) @(negedge clk);
    check("t4_no_tx_while_busy", 32'(tx_count - tb0), 32'd0);
    check("t4_active", 32'(active), 32'd1);
    hold_busy = 1'b0;
    k = 0;
    while (!transmit && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t4_tx_after_busy_fall", 32'(k), 32'd1);
    wait_done(db0);
    @(negedge clk);
    check("t4_tx_count", 32'(tx_count - tb0), 32'(NTX));

    // 5: start mid-dump and on the done cycle are ignored
    tb0 = tx_count; db0 = done_count;
    do_start(P1);
    wait_tx(tb0 + 4);
    @(negedge clk);
    big = P0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t5_saw_done", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_tx_count", 32'(tx_count - tb0), 32'(NTX));
    check("t5_done_count", 32'(done_count - db0), 32'd1);
    check("t5_active_low", 32'(active), 32'd0);

    // 6: reset after byte 5, then restart from byte 0
    tb0 = tx_count; db0 = done_count;
    do_start(P0);
    wait_tx(tb0 + 6);
    repeat (3) @(negedge clk);
    nRst = 1'b0;
    #1;
    check("t6_rst_transmit", 32'(transmit), 32'd0);
    check("t6_rst_data_tx", 32'(data_tx), 32'd0);
    check("t6_rst_active", 32'(active), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_done_after_rst", 32'(done_count - db0), 32'd0);
    tb0 = tx_count;
    do_start(P1);
    wait_done(db0);
    @(negedge clk);
    check("t6_restart_tx_count", 32'(tx_count - tb0), 32'(NTX));
    check("t6_active_low", 32'(active), 32'd0);

    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
